adc_trig_capture: RTL
=====================

# adc_trig_capture

Trigger-and-capture stage that sits directly downstream of the sample-clock divider. It turns the divided `samp_clk` into a one-cycle sample strobe and registers `adc_data` on each strobe. The samples go into a circular record buffer with a programmable pre-trigger depth, and a level/slope trigger fires the capture. Once a record is complete, the display/readout logic reads it at logical offsets.

## Interface
Parameters:
- `DW`, default 8: ADC sample width.
- `AW`, default 10: buffer address width; record depth `DEPTH = 2**AW`.
- `PRE`, default 256: pre-trigger samples per record. Legal range is 1 to `DEPTH-1`.

Ports:
- `sys_clk` input, 1 bit: system clock. The single clock for all logic.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `samp_clk` input, 1 bit: divided sample clock. It is generated in the `sys_clk` domain; a low phase and a high phase each last at least 1 `sys_clk` cycle.
- `adc_data` input, `DW` bits: ADC sample, unsigned.
- `arm` input, 1 bit: single-cycle pulse that starts a capture.
- `trig_level` input, `DW` bits: trigger threshold, unsigned.
- `trig_slope` input, 1 bit: 1 = rising edge, 0 = falling edge.
- `force_trig` input, 1 bit: pulse that forces a trigger while in WAIT.
- `rd_addr` input, `AW` bits: logical read offset; 0 is the oldest sample of the record.
- `rd_data` output, `DW` bits: registered read data.
- `busy` output, 1 bit: high in PRE, WAIT and POST.
- `done` output, 1 bit: high while in DONE.
- `triggered` output, 1 bit: one-cycle pulse on the cycle the trigger sample is written.

## Operation
- **Sample strobe:**
  - `samp_d` is `samp_clk` registered once.
  - `strobe = samp_clk & ~samp_d`.
  - All buffer writes and state counters advance only on `strobe`.
- **Write path:**
  - On `strobe` in PRE, WAIT or POST: `mem[wr_ptr] <= adc_data`, then `wr_ptr <= wr_ptr + 1`.
  - `wr_ptr` wraps modulo `DEPTH`.
  - `prev` holds the last written sample, and `prev_vld` is set after the first write of the current arm.
- **Trigger condition**, evaluated on a strobe in WAIT with `prev_vld = 1`:
  - Rising (`trig_slope = 1`): `prev < trig_level` and `adc_data >= trig_level`.
  - Falling (`trig_slope = 0`): `prev > trig_level` and `adc_data <= trig_level`.
  - Comparisons are unsigned and `DW` bits wide.
- **Forced trigger:** `force_trig` seen in WAIT sets a sticky `force_pend`. The next strobe in WAIT is then a trigger, and `force_pend` clears.
- **State machine:**
  - IDLE: on `arm`, clear `wr_ptr`, `pre_cnt`, `post_cnt`, `prev_vld` and `force_pend`, then go to PRE.
  - PRE: each strobe writes a sample and increments `pre_cnt`. When the PRE-th sample is written, go to WAIT.
    - A trigger condition occurring during PRE is ignored.
    - `force_trig` pulses received during PRE are discarded.
  - WAIT: each strobe writes a sample.
    - On the trigger strobe, latch `start = wr_ptr - PRE` (mod `DEPTH`), using `wr_ptr` before its increment. The trigger sample therefore sits at logical offset `PRE`.
    - Pulse `triggered`, then go to POST.
    - With no trigger, the buffer keeps overwriting circularly.
  - POST: each strobe writes a sample and increments `post_cnt`. When `post_cnt` reaches `DEPTH-PRE-1`, go to DONE.
    - If `PRE = DEPTH-1`, POST is passed through with zero samples and the state goes directly to DONE.
  - DONE: no writes. `arm` restarts the sequence by going to PRE with the same clears as IDLE.
- **Arm handling:** `arm` in PRE, WAIT or POST is ignored. `arm` and `strobe` in the same cycle from IDLE or DONE: the clear takes priority and no sample is written that cycle.
- **Read path:**
  - `rd_data <= mem[(start + rd_addr) mod DEPTH]` every cycle, in any state.
  - Contents are defined only in DONE. Reads never alter state.
- **Reset:**
  - State goes to IDLE.
  - `busy`, `done`, `triggered` = 0.
  - `rd_data`, `wr_ptr`, `start` and all counters = 0.
  - `prev_vld` and `force_pend` = 0.
  - Buffer contents are unspecified.
  - Reset mid-capture abandons the record.

## Timing
- Strobe is high on the first `sys_clk` cycle where `samp_clk = 1` after being 0.
  - The sample written is the `adc_data` value present in that cycle.
  - The write lands at that cycle's rising edge.
- `busy` rises on the cycle after `arm` is sampled.
- The PRE-to-WAIT and POST-to-DONE transitions occur on the same edge as the completing write.
  - `done` goes high the cycle after the last sample is written, and `busy` falls on that same cycle.
- `triggered` is high for exactly the one cycle following the trigger-sample write edge.
- Read latency: `rd_data` reflects `rd_addr` 1 `sys_clk` cycle later.
- A complete record needs exactly `DEPTH` strobes after trigger arrival, counted as PRE plus WAIT-until-trigger plus post. The minimum is `DEPTH` strobes from arm.

## Test plan
Bench parameters are `AW = 4` (DEPTH 16), `PRE = 4` and `DW = 8`, with a ramp input where `adc_data` equals the strobe index (0, 1, 2, …).

1. **Rising trigger:** arm with `trig_level = 10`, rising slope.
   - Trigger fires on sample 10.
   - `done` rises the cycle after sample 21.
   - Reading `rd_addr` 0..15 returns 6..21, with offset 4 = 10.
2. **Trigger ignored in PRE:** `trig_level = 2` with a ramp starting at 0.
   - The crossing happens during PRE and is ignored. The ramp gives no further crossing, so the block stays in WAIT and `busy = 1`.
   - `force_trig` then triggers on the next strobe, sample N. Offset 4 reads N.
3. **Falling trigger after wrap:** the input holds 200 for 30 strobes, then drops to 50. Use `trig_level = 100`, falling slope.
   - Trigger fires on the first 50.
   - Offsets 0..3 read 200 and offset 4 reads 50. This proves correct `start` wrap.
4. **Equality crossing:** `prev = 9`, `cur = 10`, level 10, rising.
   - This triggers, because the rule is `>=`.
   - A steady `prev = 10`, `cur = 10` does not trigger.
5. **Arm during busy and re-arm:** `arm` pulsed in WAIT is ignored and the record is unchanged. `arm` pulsed in DONE takes effect: `busy` = 1 the next cycle and `done` = 0.
6. **Async reset:** `rst` is asserted mid-POST between clock edges.
   - All outputs go to 0 immediately.
   - After release the block sits in IDLE and ignores strobes until `arm`.

Source files
------------

// File: rtl/adc_trig_capture.sv
// Trigger-and-capture stage: edge-detects the divided sample clock, records ADC samples
// into a circular buffer with programmable pre-trigger depth, and serves reads by logical offset.
module adc_trig_capture #(
   parameter int DW  = 8,
   parameter int AW  = 10,
   parameter int PRE = 256
) (
   input  logic          sys_clk,
   input  logic          rst,
   input  logic          samp_clk,
   input  logic [DW-1:0] adc_data,
   input  logic          arm,
   input  logic [DW-1:0] trig_level,
   input  logic          trig_slope,
   input  logic          force_trig,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic          done,
   output logic          triggered
);

   localparam int DEPTH     = 2 ** AW;
   localparam int POST_LAST = DEPTH - PRE - 2;
   localparam logic [AW-1:0] PRE_W = PRE[AW-1:0];

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

   state_t        state;
   logic [DW-1:0] mem [DEPTH];
   logic          samp_d;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] start;
   logic [AW-1:0] pre_cnt;
   logic [AW-1:0] post_cnt;
   logic [DW-1:0] prev;
   logic          prev_vld;
   logic          force_pend;

   logic          strobe;
   logic          we;
   logic          cond_rise;
   logic          cond_fall;
   logic          trig_hit;
   logic [AW-1:0] rd_idx;

   assign strobe    = samp_clk & ~samp_d;
   assign we        = strobe && (state == S_PRE || state == S_WAIT || state == S_POST);
   assign cond_rise = (prev < trig_level) && (adc_data >= trig_level);
   assign cond_fall = (prev > trig_level) && (adc_data <= trig_level);
   assign trig_hit  = (state == S_WAIT) && strobe &&
                      (force_pend || (prev_vld && (trig_slope ? cond_rise : cond_fall)));
   // Address arithmetic wraps naturally at AW bits, giving the circular offset.
   assign rd_idx    = start + rd_addr;

   // NOTE: the record buffer is deliberately left out of reset and kept in its own
   // block so it can map onto a RAM; its contents are only meaningful in DONE anyway.
   always_ff @(posedge sys_clk) begin
      if (we) mem[wr_ptr] <= adc_data;
   end

   // NOTE: every register here uses non-blocking assignment so all reads within the
   // block see the pre-edge values (e.g. start latches wr_ptr before its increment).
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         samp_d     <= 1'b0;
         wr_ptr     <= '0;
         start      <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         prev       <= '0;
         prev_vld   <= 1'b0;
         force_pend <= 1'b0;
         rd_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         triggered  <= 1'b0;
      end else begin
         samp_d    <= samp_clk;
         triggered <= 1'b0;
         rd_data   <= mem[rd_idx];

         if (we) begin
            wr_ptr   <= wr_ptr + 1'b1;
            prev     <= adc_data;
            prev_vld <= 1'b1;
         end

         case (state)
            S_IDLE, S_DONE: begin
               // Clearing on arm wins over any coincident strobe: no write happens here.
               if (arm) begin
                  wr_ptr     <= '0;
                  pre_cnt    <= '0;
                  post_cnt   <= '0;
                  prev_vld   <= 1'b0;
                  force_pend <= 1'b0;
                  state      <= S_PRE;
                  busy       <= 1'b1;
                  done       <= 1'b0;
               end
            end
            S_PRE: begin
               if (strobe) begin
                  pre_cnt <= pre_cnt + 1'b1;
                  if (int'(pre_cnt) == PRE - 1) state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (force_trig) force_pend <= 1'b1;
               if (trig_hit) begin
                  start      <= wr_ptr - PRE_W;
                  triggered  <= 1'b1;
                  force_pend <= 1'b0;
                  if (PRE == DEPTH - 1) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= S_POST;
                  end
               end
            end
            S_POST: begin
               if (strobe) begin
                  post_cnt <= post_cnt + 1'b1;
                  if (int'(post_cnt) == POST_LAST) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
